// File: rtl/counter_tick_updown.sv
// counter_tick_updown: up/down counter advanced by an internal clock-enable
// tick divider. Programmable modulus, wrap or saturate at the limits,
// synchronous clear/load, and a terminal-count pulse. Everything runs on i_clk;
// the divider only produces an enable and is never used as a clock.
module counter_tick_updown #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int DIV_COUNT = 100000000,
  parameter int DIV_W     = 27
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_sat,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tick,
  output logic             o_tc,
  output logic             o_at_limit
);

  localparam logic [WIDTH-1:0] LP_MAX      = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ONE      = WIDTH'(1);
  localparam logic [WIDTH:0]   LP_MOD      = (WIDTH + 1)'(MODULUS);
  localparam logic [DIV_W-1:0] LP_DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [DIV_W-1:0] LP_DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic [WIDTH-1:0] r_q;
  logic             r_tick;
  logic             r_tc;

  logic             w_step;
  logic             w_at_limit;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_load_q;
  logic [DIV_W-1:0] w_div_next;

  // Step strobe: last cycle of an enabled divider period.
  assign w_step = i_en & (r_div == LP_DIV_LAST);

  // Limit in the current direction, seen by both the tc pulse and the output.
  assign w_at_limit = i_up_dn ? (r_q == LP_MAX) : (r_q == '0);

  // Out-of-range load values clamp to the top of the range.
  assign w_load_q = ({1'b0, i_load_val} >= LP_MOD) ? LP_MAX : i_load_val;

  // Divider wraps after DIV_COUNT enabled cycles (stays 0 when DIV_COUNT=1).
  assign w_div_next = (r_div == LP_DIV_LAST) ? '0 : (r_div + LP_DIV_ONE);

  // Next count for a step: move one place, or wrap/hold at the limit.
  always_comb begin
    w_q_step = r_q;
    if (i_up_dn) begin
      if (r_q == LP_MAX) w_q_step = i_sat ? r_q : '0;
      else               w_q_step = r_q + LP_ONE;
    end else begin
      if (r_q == '0)     w_q_step = i_sat ? r_q : LP_MAX;
      else               w_q_step = r_q - LP_ONE;
    end
  end

  // State update with priority reset > clear > load > step.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_div  <= '0;
      r_q    <= '0;
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
    end else if (i_load) begin
      r_div  <= '0;
      r_q    <= w_load_q;
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
    end else begin
      if (i_en)   r_div <= w_div_next;
      if (w_step) r_q   <= w_q_step;
      r_tick <= w_step;
      r_tc   <= w_step & w_at_limit;
    end
  end

  assign o_q        = r_q;
  assign o_tick     = r_tick;
  assign o_tc       = r_tc;
  assign o_at_limit = w_at_limit;

endmodule
